// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if
// Handshake bundle between the execute stage (master) and the writeback
// stage (slave).
//   in_valid    execute -> wb   op present on wb_* this cycle
//   wb_result   execute -> wb   ALU result / load address
//   wb_alu2reg  execute -> wb   op writes wb_result to rd
//   wb_mem2reg  execute -> wb   op is a load
//   wb_dst_sel  execute -> wb   rd index
//   wb_raddr    execute -> wb   load byte offset
//   wb_aluop    execute -> wb   load funct3
//   stall       wb -> execute   hold outputs, in_valid not captured
// ----------------------------------------------------------------------------
interface wb_stage_if;
    logic        in_valid;
    logic [31:0] wb_result;
    logic        wb_alu2reg;
    logic        wb_mem2reg;
    logic [4:0]  wb_dst_sel;
    logic [1:0]  wb_raddr;
    logic [2:0]  wb_aluop;
    logic        stall;

    modport master (
        output in_valid, wb_result, wb_alu2reg, wb_mem2reg,
               wb_dst_sel, wb_raddr, wb_aluop,
        input  stall
    );

    modport slave (
        input  in_valid, wb_result, wb_alu2reg, wb_mem2reg,
               wb_dst_sel, wb_raddr, wb_aluop,
        output stall
    );
endinterface

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the three-stage RV32I pipeline. Captures one op per
// cycle from execute, waits on dmem read data for loads, aligns and
// sign/zero-extends load data and writes the 32x32 register file. Serves
// the two decode read ports with a same-cycle write-through bypass.
//
// Ports
//   clk, resetb            clock, asynchronous active-low reset
//   bus (slave)            execute handshake bundle (in_valid, wb_*, stall)
//   dmem_rdata/rvalid      data memory read word and its valid
//   rs1_sel/rs2_sel        decode read port indices
//   rs1_data/rs2_data      decode read port data (combinational)
//   rd_we/rd_sel/rd_data   register write happening this cycle
//   load_fault             one-cycle pulse on misaligned/illegal load or timeout
//   rdcycle/rdinstret      performance counters
//
// Optional feature: define WB_PERF_COUNTERS_EN to build rdcycle/rdinstret;
// otherwise both read 0.
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int MEM_TIMEOUT = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            resetb,
    wb_stage_if.slave       bus,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_rvalid,
    input  logic [4:0]      rs1_sel,
    input  logic [4:0]      rs2_sel,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_we,
    output logic [4:0]      rd_sel,
    output logic [XLEN-1:0] rd_data,
    output logic            load_fault,
    output logic [63:0]     rdcycle,
    output logic [63:0]     rdinstret
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    // Funct3 / offset combinations that cannot be serviced as a load.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed byte/half of the read word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = rdata;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_t            state_r, state_next_s;
    logic [CW-1:0]     cnt_r;
    logic              valid_r;
    logic [XLEN-1:0]   result_r;
    logic              alu2reg_r;
    logic              mem2reg_r;
    logic [4:0]        dst_r;
    logic [1:0]        raddr_r;
    logic [2:0]        aluop_r;
    logic [XLEN-1:0]   regs_r [0:31];

    logic              bad_s;
    logic              timeout_s;
    logic              write_s;
    logic              fault_s;
    logic              stall_s;
    logic [XLEN-1:0]   ext_s;

    assign bad_s     = load_bad(aluop_r, raddr_r);
    assign timeout_s = (cnt_r == CW'(MEM_TIMEOUT - 1));
    assign ext_s     = load_extend(dmem_rdata, raddr_r, aluop_r);
    assign bus.stall = stall_s;

    // FSM state register and WAIT_MEM cycle counter.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == WAIT_MEM) && (state_next_s == WAIT_MEM)) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_r && mem2reg_r && !bad_s && !dmem_rvalid) begin
                    state_next_s = WAIT_MEM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_MEM: begin
                if (dmem_rvalid || timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_MEM;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: write/fault/stall decisions for the op held in the stage.
    // mem2reg takes priority over alu2reg when both are set.
    always_comb begin
        write_s = 1'b0;
        fault_s = 1'b0;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_r && mem2reg_r) begin
                    if (bad_s) begin
                        fault_s = 1'b1;
                    end else if (dmem_rvalid) begin
                        write_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                    end
                end else if (valid_r) begin
                    write_s = alu2reg_r;
                end else begin
                    write_s = 1'b0;
                end
            end
            WAIT_MEM: begin
                if (dmem_rvalid) begin
                    write_s = 1'b1;
                end else if (timeout_s) begin
                    fault_s = 1'b1;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                write_s = 1'b0;
            end
        endcase
    end

    // Write port; x0 is never written.
    always_comb begin
        rd_we      = write_s && (dst_r != 5'd0);
        load_fault = fault_s;
        if (rd_we) begin
            rd_sel  = dst_r;
            rd_data = mem2reg_r ? ext_s : result_r;
        end else begin
            rd_sel  = 5'd0;
            rd_data = '0;
        end
    end

    // Stage capture register; holds its contents while stalled.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            valid_r   <= 1'b0;
            result_r  <= '0;
            alu2reg_r <= 1'b0;
            mem2reg_r <= 1'b0;
            dst_r     <= 5'd0;
            raddr_r   <= 2'd0;
            aluop_r   <= 3'd0;
        end else if (!stall_s) begin
            valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                result_r  <= bus.wb_result;
                alu2reg_r <= bus.wb_alu2reg;
                mem2reg_r <= bus.wb_mem2reg;
                dst_r     <= bus.wb_dst_sel;
                raddr_r   <= bus.wb_raddr;
                aluop_r   <= bus.wb_aluop;
            end
        end
    end

    // Register file.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (rd_we) begin
            regs_r[rd_sel] <= rd_data;
        end
    end

    // Decode read ports with same-cycle bypass of the write in progress.
    always_comb begin
        if (rs1_sel == 5'd0) begin
            rs1_data = '0;
        end else if (rd_we && (rd_sel == rs1_sel)) begin
            rs1_data = rd_data;
        end else begin
            rs1_data = regs_r[rs1_sel];
        end
        if (rs2_sel == 5'd0) begin
            rs2_data = '0;
        end else if (rd_we && (rd_sel == rs2_sel)) begin
            rs2_data = rd_data;
        end else begin
            rs2_data = regs_r[rs2_sel];
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    logic [63:0] rdcycle_r;
    logic [63:0] rdinstret_r;
    logic        retire_s;

    // An op leaves the stage whenever it is present and not stalled.
    assign retire_s  = !stall_s && (valid_r || (state_r == WAIT_MEM));
    assign rdcycle   = rdcycle_r;
    assign rdinstret = rdinstret_r;

    // Cycle and retired-op counters.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rdcycle_r   <= 64'd0;
            rdinstret_r <= 64'd0;
        end else begin
            rdcycle_r <= rdcycle_r + 64'd1;
            if (retire_s) begin
                rdinstret_r <= rdinstret_r + 64'd1;
            end
        end
    end
`else
    assign rdcycle   = 64'd0;
    assign rdinstret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Directed testbench for wb_stage: ALU write with bypass, load extension,
// memory wait and stall release, load faults and timeout, x0 handling,
// reset during a pending load, and performance counters.
// ----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        resetb;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_we;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        load_fault;
    logic [63:0] rdcycle;
    logic [63:0] rdinstret;
    logic [63:0] cyc;

    int checks;
    int failures;

    wb_stage_if bus ();

    wb_stage #(.MEM_TIMEOUT(16), .XLEN(32)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .bus         (bus.slave),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_we       (rd_we),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .load_fault  (load_fault),
        .rdcycle     (rdcycle),
        .rdinstret   (rdinstret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles elapsed since reset release, reference for rdcycle.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) cyc <= 64'd0;
        else         cyc <= cyc + 64'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [4:0] d, input logic [31:0] v);
        bus.in_valid   = 1'b1;
        bus.wb_alu2reg = 1'b1;
        bus.wb_mem2reg = 1'b0;
        bus.wb_dst_sel = d;
        bus.wb_result  = v;
        bus.wb_raddr   = 2'd0;
        bus.wb_aluop   = 3'd0;
    endtask

    task automatic drive_load(input logic [4:0] d, input logic [2:0] f3, input logic [1:0] off);
        bus.in_valid   = 1'b1;
        bus.wb_alu2reg = 1'b0;
        bus.wb_mem2reg = 1'b1;
        bus.wb_dst_sel = d;
        bus.wb_result  = {30'd0, off};
        bus.wb_raddr   = off;
        bus.wb_aluop   = f3;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3,
                             input logic [1:0] off, input logic [31:0] exp);
        drive_load(5'd6, f3, off);
        next_cycle;
        bus.in_valid = 1'b0;
        dmem_rvalid  = 1'b1;
        #1;
        check_eq({tag, "_data"}, {32'd0, rd_data}, {32'd0, exp});
        check_eq({tag, "_we"}, {63'd0, rd_we}, 64'd1);
        next_cycle;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        resetb         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.wb_result  = 32'd0;
        bus.wb_alu2reg = 1'b0;
        bus.wb_mem2reg = 1'b0;
        bus.wb_dst_sel = 5'd0;
        bus.wb_raddr   = 2'd0;
        bus.wb_aluop   = 3'd0;
        dmem_rdata     = 32'd0;
        dmem_rvalid    = 1'b0;
        rs1_sel        = 5'd0;
        rs2_sel        = 5'd0;

        // Reset state
        repeat (2) next_cycle;
        #1;
        check_eq("rst_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("rst_we", {63'd0, rd_we}, 64'd0);
        check_eq("rst_sel", {59'd0, rd_sel}, 64'd0);
        check_eq("rst_data", {32'd0, rd_data}, 64'd0);
        check_eq("rst_fault", {63'd0, load_fault}, 64'd0);
        check_eq("rst_cycle", rdcycle, 64'd0);
        check_eq("rst_instret", rdinstret, 64'd0);
        resetb = 1'b1;
        next_cycle;

        // ALU write with same-cycle bypass
        drive_alu(5'd5, 32'h0000_1234);
        next_cycle;
        bus.in_valid = 1'b0;
        rs1_sel      = 5'd5;
        #1;
        check_eq("alu_we", {63'd0, rd_we}, 64'd1);
        check_eq("alu_sel", {59'd0, rd_sel}, 64'd5);
        check_eq("alu_data", {32'd0, rd_data}, 64'h1234);
        check_eq("alu_bypass", {32'd0, rs1_data}, 64'h1234);
        next_cycle;
        #1;
        check_eq("alu_we_off", {63'd0, rd_we}, 64'd0);
        check_eq("alu_array", {32'd0, rs1_data}, 64'h1234);

        // Load extension
        dmem_rdata = 32'h80FF_7F01;
        load_case("lb3",  3'b000, 2'd3, 32'hFFFF_FF80);
        load_case("lbu1", 3'b100, 2'd1, 32'h0000_007F);
        load_case("lh2",  3'b001, 2'd2, 32'hFFFF_80FF);
        load_case("lhu0", 3'b101, 2'd0, 32'h0000_7F01);
        load_case("lw",   3'b010, 2'd0, 32'h80FF_7F01);
        rs2_sel = 5'd6;
        #1;
        check_eq("lw_array", {32'd0, rs2_data}, 64'h80FF_7F01);

        // Memory wait, stall release, held op captured afterwards
        drive_load(5'd7, 3'b010, 2'd0);
        next_cycle;
        drive_alu(5'd8, 32'h0000_00AA);
        #1;
        check_eq("wait_c1_stall", {63'd0, bus.stall}, 64'd1);
        next_cycle;
        #1;
        check_eq("wait_c2_stall", {63'd0, bus.stall}, 64'd1);
        check_eq("wait_c2_we", {63'd0, rd_we}, 64'd0);
        next_cycle;
        #1;
        check_eq("wait_c3_stall", {63'd0, bus.stall}, 64'd1);
        next_cycle;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        #1;
        check_eq("wait_c4_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("wait_c4_sel", {59'd0, rd_sel}, 64'd7);
        check_eq("wait_c4_data", {32'd0, rd_data}, 64'hCAFE_F00D);
        next_cycle;
        dmem_rvalid  = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("held_we", {63'd0, rd_we}, 64'd1);
        check_eq("held_sel", {59'd0, rd_sel}, 64'd8);
        check_eq("held_data", {32'd0, rd_data}, 64'hAA);
        next_cycle;

        // Misaligned LW faults without writing
        drive_load(5'd9, 3'b010, 2'd2);
        next_cycle;
        bus.in_valid = 1'b0;
        dmem_rvalid  = 1'b1;
        rs1_sel      = 5'd9;
        #1;
        check_eq("mis_fault", {63'd0, load_fault}, 64'd1);
        check_eq("mis_we", {63'd0, rd_we}, 64'd0);
        check_eq("mis_stall", {63'd0, bus.stall}, 64'd0);
        next_cycle;
        dmem_rvalid = 1'b0;
        #1;
        check_eq("mis_pulse", {63'd0, load_fault}, 64'd0);
        check_eq("mis_x9", {32'd0, rs1_data}, 64'd0);

        // Memory timeout after 16 WAIT_MEM cycles
        drive_load(5'd10, 3'b010, 2'd0);
        next_cycle;
        bus.in_valid = 1'b0;
        rs1_sel      = 5'd10;
        #1;
        check_eq("to_idle_stall", {63'd0, bus.stall}, 64'd1);
        for (int i = 1; i <= 16; i++) begin
            next_cycle;
            #1;
            if (i == 15) begin
                check_eq("to_w15_fault", {63'd0, load_fault}, 64'd0);
                check_eq("to_w15_stall", {63'd0, bus.stall}, 64'd1);
            end else if (i == 16) begin
                check_eq("to_w16_fault", {63'd0, load_fault}, 64'd1);
                check_eq("to_w16_we", {63'd0, rd_we}, 64'd0);
            end
        end
        next_cycle;
        #1;
        check_eq("to_after_fault", {63'd0, load_fault}, 64'd0);
        check_eq("to_after_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("to_x10", {32'd0, rs1_data}, 64'd0);

        // x0 write is suppressed
        drive_alu(5'd0, 32'hFFFF_FFFF);
        next_cycle;
        bus.in_valid = 1'b0;
        rs1_sel      = 5'd0;
        #1;
        check_eq("x0_we", {63'd0, rd_we}, 64'd0);
        check_eq("x0_read", {32'd0, rs1_data}, 64'd0);
        next_cycle;

        // Reset during a pending load
        drive_load(5'd11, 3'b010, 2'd0);
        next_cycle;
        bus.in_valid = 1'b0;
        next_cycle;
        #1;
        check_eq("rstw_pre_stall", {63'd0, bus.stall}, 64'd1);
        resetb  = 1'b0;
        rs1_sel = 5'd5;
        rs2_sel = 5'd7;
        #1;
        check_eq("rstw_stall", {63'd0, bus.stall}, 64'd0);
        check_eq("rstw_x5", {32'd0, rs1_data}, 64'd0);
        check_eq("rstw_x7", {32'd0, rs2_data}, 64'd0);
        next_cycle;
        resetb      = 1'b1;
        dmem_rvalid = 1'b1;
        rs1_sel     = 5'd11;
        #1;
        check_eq("rstw_no_write", {63'd0, rd_we}, 64'd0);
        check_eq("rstw_x11", {32'd0, rs1_data}, 64'd0);
        next_cycle;
        dmem_rvalid = 1'b0;

        // Performance counters: 10 ALU ops plus one load waiting 2 cycles
        for (int i = 0; i < 10; i++) begin
            drive_alu(5'(i + 1), 32'(i * 3));
            next_cycle;
        end
        drive_load(5'd12, 3'b010, 2'd0);
        next_cycle;
        bus.in_valid = 1'b0;
        next_cycle;
        next_cycle;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        #1;
        check_eq("perf_load_we", {63'd0, rd_we}, 64'd1);
        next_cycle;
        dmem_rvalid = 1'b0;
        #1;
`ifdef WB_PERF_COUNTERS_EN
        check_eq("perf_instret", rdinstret, 64'd11);
        check_eq("perf_cycle", rdcycle, cyc);
`else
        check_eq("perf_instret", rdinstret, 64'd0);
        check_eq("perf_cycle", rdcycle, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
